div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: none; data width fixed at 32 bits, divider result width 64 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents a divide operation.
REQ-005 reqN_op  input  2  00 DIV, 01 MOD, 10 DIVU, 11 MODU.
REQ-006 reqN_src1 / reqN_src2  input  32 each  dividend / divisor.
REQ-007 reqN_ready  output  1  scheduler accepts requester N this cycle.
REQ-008 flushN  input  1  cancel requester N's pending or in-flight operation.
REQ-009 respN_valid  output  1  one-cycle pulse, respN_data valid.
REQ-010 respN_data  output  32  quotient or remainder per captured op.
REQ-011 div_start  output  1  held high while the divider owns an operation.
REQ-012 div_cancel  output  1  one-cycle abort pulse to the divider.
REQ-013 div_signed  output  1  1 for DIV/MOD.
REQ-014 div_op1 / div_op2  output  32 each  captured operands, stable while div_start=1.
REQ-015 div_result  input  64  [63:32] remainder, [31:0] quotient.
REQ-016 div_done  input  1  divider result valid.
REQ-017 busy  output  1  state != IDLE.

Function
REQ-018 States: IDLE, BUSY, ZERO, DRAIN.
REQ-019 Arbitration: round-robin pointer rr; in IDLE, grant goes to requester rr if valid, else the other; rr toggles to the non-granted requester on each acceptance.
REQ-020 reqN_ready = (state==IDLE) & grant==N & ~flushN; acceptance = reqN_valid & reqN_ready; at most one acceptance per cycle.
REQ-021 On acceptance: capture owner, op, src1, src2; if src2==0 go ZERO, else go BUSY.
REQ-022 BUSY: div_start=1, div_signed=~op[1], div_op1/op2 = captured operands; wait on div_done with no cycle limit.
REQ-023 BUSY & div_done & ~flush(owner): next cycle resp(owner)_valid=1, data = div_result[31:0] for DIV/DIVU, div_result[63:32] for MOD/MODU; state -> DRAIN.
REQ-024 DRAIN: div_start=0 for exactly one cycle, then IDLE; divider is never restarted without an intervening start-low cycle.
REQ-025 ZERO: divider untouched; next cycle resp(owner)_valid=1, data = 32'h0 for DIV/DIVU, captured src1 for MOD/MODU; state -> IDLE.
REQ-026 flush(owner) in BUSY: div_cancel=1 and div_start=0 same cycle, no response, state -> DRAIN.
REQ-027 flush(owner) coincident with div_done: flush wins, no response.
REQ-028 flush(owner) in ZERO: no response, state -> IDLE.
REQ-029 flush of the non-owner is ignored outside IDLE; in IDLE it only gates that requester's ready.
REQ-030 respN_valid never asserted for both requesters in one cycle; respN_data is 0 when respN_valid=0.
REQ-031 Minimum request-to-response latency: ZERO path 2 cycles from acceptance; divider path = divider latency + 1.

Reset
REQ-032 rst: state=IDLE, rr=0, all outputs 0 (div_start, div_cancel, resp*, busy), captured registers cleared.
REQ-033 rst during BUSY abandons the operation with no response and no div_cancel pulse; the divider shares rst.
REQ-034 First cycle after rst release: requester 0 wins if both valid.

Verification
REQ-035 Req0 DIV src1=-7 (32'hFFFF_FFF9), src2=2; divider returns quotient -3, remainder -1 -> resp0_data=32'hFFFF_FFFD one cycle after div_done, then one DRAIN cycle with div_start=0.
REQ-036 Req1 MODU src1=100, src2=0 -> div_start never asserted, resp1_valid 2 cycles after acceptance with data=100.
REQ-037 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; no double responses.
REQ-038 Req0 accepted, flush0 asserted 5 cycles into BUSY -> div_cancel pulse 1 cycle, no resp0, ready again after DRAIN.
REQ-039 flush0 in same cycle as div_done -> no resp0_valid; flush1 in same cycle has no effect on owner 0's response.
REQ-040 rst asserted mid-BUSY -> next cycle all outputs 0, state IDLE; new request accepted immediately after release.

Source files
------------

// File: rtl/div_sched.sv
// Two-requester front end for a shared iterative divider: round-robin arbitration,
// divide-by-zero short-circuit, per-requester flush and a one-cycle start-low drain.
module div_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        req1_ready,
  input  logic        flush0,
  input  logic        flush1,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [63:0] div_result,
  input  logic        div_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        rr_q;
  logic        owner_q;
  logic [1:0]  op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;

  logic        grant;
  logic        accept;
  logic [1:0]  sel_op;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic        flush_owner;
  logic        resp_fire;
  logic [31:0] resp_val;

  // Pointer holder wins if it is asking; otherwise the other requester is offered the slot.
  assign grant = (rr_q ? req1_valid : req0_valid) ? rr_q : ~rr_q;

  assign req0_ready = (state_q == IDLE) & ~grant & ~flush0;
  assign req1_ready = (state_q == IDLE) &  grant & ~flush1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel_op   = grant ? req1_op   : req0_op;
  assign sel_src1 = grant ? req1_src1 : req0_src1;
  assign sel_src2 = grant ? req1_src2 : req0_src2;

  assign flush_owner = owner_q ? flush1 : flush0;

  assign busy       = (state_q != IDLE);
  assign div_signed = (state_q == BUSY) & ~op_q[1];
  assign div_op1    = (state_q == BUSY) ? src1_q : 32'h0;
  assign div_op2    = (state_q == BUSY) ? src2_q : 32'h0;

  always_comb begin
    state_d    = state_q;
    resp_fire  = 1'b0;
    resp_val   = 32'h0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (sel_src2 == 32'h0) ? ZERO : BUSY;
      end
      BUSY: begin
        // A flush beats a coincident div_done: the result is dropped.
        if (flush_owner) begin
          div_cancel = 1'b1;
          state_d    = DRAIN;
        end else begin
          div_start = 1'b1;
          if (div_done) begin
            resp_fire = 1'b1;
            resp_val  = op_q[0] ? div_result[63:32] : div_result[31:0];
            state_d   = DRAIN;
          end
        end
      end
      ZERO: begin
        state_d = IDLE;
        if (!flush_owner) begin
          resp_fire = 1'b1;
          resp_val  = op_q[0] ? src1_q : 32'h0;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      op_q        <= 2'b00;
      src1_q      <= 32'h0;
      src2_q      <= 32'h0;
      resp0_valid <= 1'b0;
      resp0_data  <= 32'h0;
      resp1_valid <= 1'b0;
      resp1_data  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant;
        op_q    <= sel_op;
        src1_q  <= sel_src1;
        src2_q  <= sel_src2;
        rr_q    <= ~grant;
      end
      resp0_valid <= resp_fire & ~owner_q;
      resp0_data  <= (resp_fire & ~owner_q) ? resp_val : 32'h0;
      resp1_valid <= resp_fire & owner_q;
      resp1_data  <= (resp_fire & owner_q) ? resp_val : 32'h0;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched; responses are checked against a queue of
// hand-computed expectations by an independent monitor.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic        req0_ready, req1_ready;
  logic        flush0 = 1'b0, flush1 = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        div_start, div_cancel, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result = '0;
  logic        div_done = 1'b0;
  logic        busy;

  int passed = 0;
  int total  = 0;
  logic [32:0] exp_q[$];

  div_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_ready(req1_ready),
    .flush0(flush0), .flush1(flush1),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2),
    .div_result(div_result), .div_done(div_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input bit port, input logic valid, input logic [1:0] op,
                               input logic [31:0] src1, input logic [31:0] src2);
    if (port) begin
      req1_valid = valid; req1_op = op; req1_src1 = src1; req1_src2 = src2;
    end else begin
      req0_valid = valid; req0_op = op; req0_src1 = src1; req0_src2 = src2;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (resp0_valid || resp1_valid)) begin
      if (resp0_valid && resp1_valid) checkOutput("dual_resp", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected_resp: got r0=%0b/%h r1=%0b/%h, required none",
                 resp0_valid, resp0_data, resp1_valid, resp1_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        checkOutput("resp_port", {31'd0, resp1_valid}, {31'd0, e[32]});
        checkOutput("resp_data", resp1_valid ? resp1_data : resp0_data, e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    step(); step();
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", div_start, 0);
    checkOutput("rst_cancel", div_cancel, 0);
    checkOutput("rst_resp", {resp1_valid, resp0_valid}, 0);
    step(); rst = 1'b0;

    // Signed divide -7/2 through the divider
    applyStimulus(0, 1, 2'b00, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk); checkOutput("t1_ready0", req0_ready, 1);
    step(); applyStimulus(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("t1_start", div_start, 1);
    checkOutput("t1_signed", div_signed, 1);
    checkOutput("t1_op1", div_op1, 32'hFFFF_FFF9);
    checkOutput("t1_op2", div_op2, 32'd2);
    step(); step();
    div_done = 1'b1; div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    exp_q.push_back({1'b0, 32'hFFFF_FFFD});
    @(negedge clk); checkOutput("t1_no_early_resp", resp0_valid, 0);
    step(); div_done = 1'b0; div_result = '0;
    @(negedge clk);
    checkOutput("t1_drain_start", div_start, 0);
    checkOutput("t1_drain_busy", busy, 1);
    step();
    @(negedge clk); checkOutput("t1_idle", busy, 0);

    // MODU by zero on requester 1
    step(); applyStimulus(1, 1, 2'b11, 32'd100, 32'd0);
    @(negedge clk); checkOutput("t2_ready1", req1_ready, 1);
    exp_q.push_back({1'b1, 32'd100});
    step(); applyStimulus(1, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("t2_zero_start", div_start, 0);
    checkOutput("t2_zero_busy", busy, 1);
    step();
    @(negedge clk);
    checkOutput("t2_after_start", div_start, 0);
    checkOutput("t2_after_busy", busy, 0);

    // Both requesters continuously valid: grants alternate 0,1,0,1
    step();
    applyStimulus(0, 1, 2'b11, 32'd11, 32'd0);
    applyStimulus(1, 1, 2'b11, 32'd22, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t3_grant_ready", (i % 2) ? req1_ready : req0_ready, 1);
      checkOutput("t3_other_ready", (i % 2) ? req0_ready : req1_ready, 0);
      exp_q.push_back((i % 2) ? {1'b1, 32'd22} : {1'b0, 32'd11});
      step();
      if (i == 3) begin
        applyStimulus(0, 0, 2'b00, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0);
      end
      @(negedge clk); checkOutput("t3_zero_nostart", div_start, 0);
      step();
    end

    // Flush of the owner five cycles into BUSY
    step(); applyStimulus(0, 1, 2'b00, 32'd50, 32'd5);
    @(negedge clk); checkOutput("t4_ready0", req0_ready, 1);
    step(); applyStimulus(0, 0, 2'b00, 0, 0);
    repeat (4) step();
    flush0 = 1'b1;
    @(negedge clk);
    checkOutput("t4_cancel", div_cancel, 1);
    checkOutput("t4_cancel_start", div_start, 0);
    step(); flush0 = 1'b0;
    @(negedge clk);
    checkOutput("t4_cancel_pulse", div_cancel, 0);
    checkOutput("t4_drain_busy", busy, 1);
    step();
    @(negedge clk); checkOutput("t4_idle", busy, 0);

    // flush0 coincident with div_done drops the result
    step(); applyStimulus(0, 1, 2'b10, 32'd9, 32'd4);
    @(negedge clk); checkOutput("t5_ready0", req0_ready, 1);
    step(); applyStimulus(0, 0, 2'b00, 0, 0);
    step();
    div_done = 1'b1; div_result = {32'd1, 32'd2}; flush0 = 1'b1;
    @(negedge clk); checkOutput("t5_cancel", div_cancel, 1);
    step(); div_done = 1'b0; div_result = '0; flush0 = 1'b0;
    @(negedge clk);
    checkOutput("t5_no_resp", resp0_valid, 0);
    checkOutput("t5_drain_busy", busy, 1);
    step();

    // flush1 with div_done does not disturb owner 0 (MOD -> remainder)
    applyStimulus(0, 1, 2'b01, 32'd9, 32'd4);
    @(negedge clk); checkOutput("t6_ready0", req0_ready, 1);
    step(); applyStimulus(0, 0, 2'b00, 0, 0);
    step();
    div_done = 1'b1; div_result = {32'd1, 32'd2}; flush1 = 1'b1;
    exp_q.push_back({1'b0, 32'd1});
    @(negedge clk);
    checkOutput("t6_no_cancel", div_cancel, 0);
    checkOutput("t6_start", div_start, 1);
    step(); div_done = 1'b0; div_result = '0; flush1 = 1'b0;
    @(negedge clk); checkOutput("t6_drain_start", div_start, 0);
    step();
    @(negedge clk); checkOutput("t6_idle", busy, 0);

    // Reset mid-BUSY, then requester 0 wins the first cycle after release
    step(); applyStimulus(1, 1, 2'b00, 32'd7, 32'd3);
    @(negedge clk); checkOutput("t7_ready1", req1_ready, 1);
    step(); applyStimulus(1, 0, 2'b00, 0, 0);
    step();
    @(negedge clk); checkOutput("t7_start", div_start, 1);
    step(); rst = 1'b1;
    step();
    @(negedge clk);
    checkOutput("t7_rst_start", div_start, 0);
    checkOutput("t7_rst_cancel", div_cancel, 0);
    checkOutput("t7_rst_busy", busy, 0);
    checkOutput("t7_rst_resp", {resp1_valid, resp0_valid}, 0);
    checkOutput("t7_rst_op1", div_op1, 0);
    step(); rst = 1'b0;
    applyStimulus(0, 1, 2'b11, 32'd5, 32'd0);
    applyStimulus(1, 1, 2'b11, 32'd6, 32'd0);
    @(negedge clk);
    checkOutput("t7_first_ready0", req0_ready, 1);
    checkOutput("t7_first_ready1", req1_ready, 0);
    exp_q.push_back({1'b0, 32'd5});
    step();
    applyStimulus(0, 0, 2'b00, 0, 0);
    applyStimulus(1, 0, 2'b00, 0, 0);
    step();
    @(negedge clk);
    repeat (3) step();

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
